rv32i_writeback: RTL and testbench
==================================

# rv32i_writeback

Writeback stage directly upstream of the RV32I register file write port. It accepts retiring results from the execute stage via a valid/ready handshake. For loads it waits for the data memory response, then performs byte/halfword extraction and sign/zero extension. It drives a registered single-cycle write (rd_addr/rd_data/rd_we) into the register file and publishes a pending-write bitmap that decode uses for hazard stalls.

## Interface
- TIMEOUT_CYCLES, 255: cycles in WAIT_MEM without a response before a load is abandoned. Legal range 1..65535. The counter width is ceil(log2(TIMEOUT_CYCLES+1)).

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute presents a retiring instruction.
- ex_ready  out  1  writeback accepts this cycle. Combinational: 1 iff state is IDLE.
- ex_rd  in  5  destination register.
- ex_result  in  32  ALU result. Ignored for loads.
- ex_is_load  in  1  instruction is a load.
- ex_funct3  in  3  load width: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- ex_addr_lo  in  2  load effective address bits [1:0].
- mem_rsp_valid  in  1  load data returned this cycle.
- mem_rsp_data  in  32  aligned 32-bit word containing the load target.
- rd_addr  out  5  register file write address.
- rd_data  out  32  register file write data.
- rd_we  out  1  register file write enable. One-cycle pulse.
- busy_mask  out  32  bit i = 1 means a write to xi is pending or in progress.
- load_fault  out  1  one-cycle pulse when a load is abandoned on timeout.

## Operation
- States: IDLE, WAIT_MEM. Reset enters IDLE.
- Handshake: a transfer occurs on an edge where ex_valid && ex_ready.

IDLE, transfer of a non-load:
- At that edge: rd_addr<=ex_rd, rd_data<=ex_result, rd_we<=(ex_rd!=0).
- Stay in IDLE. Back-to-back non-loads are accepted every cycle.

IDLE, transfer of a load:
- Latch ex_rd, ex_funct3 and ex_addr_lo. Clear the timeout counter. Move to WAIT_MEM.
- rd_we<=0 at that edge.

WAIT_MEM:
- ex_ready=0.
- On mem_rsp_valid, compute the load result:
  - byte = mem_rsp_data >> (8*addr_lo).
  - half = addr_lo[1] ? data[31:16] : data[15:0]. addr_lo[0] is ignored.
  - LB/LH sign-extend. LBU/LHU zero-extend. LW passes the word through and ignores addr_lo.
  - funct3 011, 110 and 111 are treated as LW.
- At the response edge: rd_addr<=latched rd, rd_data<=extracted value, rd_we<=(rd!=0), return to IDLE.
- Without a response, the counter increments each cycle.
- When the counter equals TIMEOUT_CYCLES-1 and there is no response: at that edge, load_fault<=1 for one cycle, no write occurs, and the state returns to IDLE.
- A response in the same cycle as the timeout threshold wins: the load completes and there is no fault.

Other rules:
- mem_rsp_valid in IDLE is ignored, with no write and no fault. A late response after a timeout is therefore dropped.
- busy_mask[i] sets at the acceptance edge of any instruction with rd=i!=0.
- busy_mask[i] clears at the edge that ends the rd_we cycle for i, or at the timeout edge.
- If a set and a clear of the same bit fall on the same edge, set wins.
- busy_mask[0] is always 0.
- rd_we is deasserted at every edge that does not launch a new write.

## Timing
- Reset: state IDLE, rd_addr=0, rd_data=0, rd_we=0, busy_mask=0, load_fault=0, counter=0, latched fields=0. ex_ready reads 1.
- Reset asserted mid-load abandons the load with no write and no fault. A response after reset is ignored.
- ALU latency: accepted at edge N, rd_we high in cycle N+1, register file updated at edge N+2.
- Load latency: response at edge M, rd_we high in cycle M+1.
- busy_mask[rd] is high from the cycle after acceptance through the rd_we cycle inclusive. This covers the cycle in which the register file's asynchronous read still returns the stale value.
- Minimum load occupancy is 2 cycles: accept, then a response on the first WAIT_MEM cycle. ex_ready is low only during WAIT_MEM.

## Test plan
- Reset, then ALU x5=0xDEADBEEF accepted at edge N: rd_we=1, rd_addr=5, rd_data=0xDEADBEEF in cycle N+1 only. busy_mask=0x20 in cycle N+1, 0 at N+2.
- ALU to x0 with result 0x1234: rd_we stays 0 and busy_mask stays 0. Then back-to-back ALU writes x1=1, x2=2 on consecutive edges: two consecutive rd_we pulses, and busy_mask shows 0x2 then 0x4.
- Loads with mem_rsp_data=0x80FF7F01:
  - LB addr_lo=3 → 0xFFFFFF80.
  - LBU addr_lo=1 → 0x0000007F.
  - LH addr_lo=2 → 0xFFFF80FF.
  - LHU addr_lo=3 → 0x000080FF.
  - LW → 0x80FF7F01.
- Load to x7 with the response 3 cycles after entering WAIT_MEM: ex_ready=0 for 3 cycles, ex_valid held upstream until ready, busy_mask[7]=1 throughout, and write in the cycle after the response.
- TIMEOUT_CYCLES=4, load to x9 with no response: load_fault pulses once after 4 WAIT_MEM cycles, no rd_we, busy_mask[9] clears, and a later mem_rsp_valid is ignored. Response on the 4th cycle: write occurs with no fault.
- rst_n pulsed low during WAIT_MEM: all outputs 0 and IDLE immediately, and a following mem_rsp_valid produces no write.

Source files
------------

// File: rtl/rv32i_writeback_if.sv
// Execute-to-writeback retire bundle.
// Valid/ready handshake plus the fields a retiring instruction carries.
interface rv32i_writeback_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;

  modport master (
    output ex_valid,
    output ex_rd,
    output ex_result,
    output ex_is_load,
    output ex_funct3,
    output ex_addr_lo,
    input  ex_ready
  );

  modport slave (
    input  ex_valid,
    input  ex_rd,
    input  ex_result,
    input  ex_is_load,
    input  ex_funct3,
    input  ex_addr_lo,
    output ex_ready
  );
endinterface

// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: retires ALU results and loads into the regfile
// write port, tracks pending destinations for decode hazard stalls.
module rv32i_writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  rv32i_writeback_if.slave ex,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        rd_we,
  output logic [31:0] busy_mask,
  output logic        load_fault
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_f3_q, ld_f3_d;
  logic [1:0]  ld_lo_q, ld_lo_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_we_q, rd_we_d;
  logic        fault_q, fault_d;
  logic [31:0] busy_q, busy_d;

  logic        accept;
  logic [31:0] set_m, clr_m;
  logic [31:0] shifted;
  logic [7:0]  bv;
  logic [15:0] hv;
  logic [31:0] ld_val;

  assign ex.ex_ready = (state_q == IDLE);
  assign accept = ex.ex_valid && ex.ex_ready;

  assign shifted = mem_rsp_data >> {ld_lo_q, 3'b000};
  assign bv = shifted[7:0];
  assign hv = ld_lo_q[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];

  always_comb begin
    ld_val = mem_rsp_data;
    unique case (ld_f3_q)
      3'b000:  ld_val = {{24{bv[7]}}, bv};
      3'b001:  ld_val = {{16{hv[15]}}, hv};
      3'b100:  ld_val = {24'd0, bv};
      3'b101:  ld_val = {16'd0, hv};
      default: ld_val = mem_rsp_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ld_rd_d   = ld_rd_q;
    ld_f3_d   = ld_f3_q;
    ld_lo_d   = ld_lo_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    rd_we_d   = 1'b0;
    fault_d   = 1'b0;
    set_m     = '0;
    clr_m     = '0;

    if (rd_we_q) clr_m[rd_addr_q] = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (ex.ex_rd != 5'd0) set_m[ex.ex_rd] = 1'b1;
          if (ex.ex_is_load) begin
            ld_rd_d = ex.ex_rd;
            ld_f3_d = ex.ex_funct3;
            ld_lo_d = ex.ex_addr_lo;
            cnt_d   = '0;
            state_d = WAIT_MEM;
          end else begin
            rd_addr_d = ex.ex_rd;
            rd_data_d = ex.ex_result;
            rd_we_d   = (ex.ex_rd != 5'd0);
          end
        end
      end
      WAIT_MEM: begin
        // A response on the threshold cycle takes priority over the timeout.
        if (mem_rsp_valid) begin
          rd_addr_d = ld_rd_q;
          rd_data_d = ld_val;
          rd_we_d   = (ld_rd_q != 5'd0);
          state_d   = IDLE;
        end else if (cnt_q == TO_LAST) begin
          fault_d = 1'b1;
          clr_m[ld_rd_q] = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (busy_q & ~clr_m) | set_m;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ld_rd_q   <= '0;
      ld_f3_q   <= '0;
      ld_lo_q   <= '0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_we_q   <= 1'b0;
      fault_q   <= 1'b0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ld_rd_q   <= ld_rd_d;
      ld_f3_q   <= ld_f3_d;
      ld_lo_q   <= ld_lo_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      rd_we_q   <= rd_we_d;
      fault_q   <= fault_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_addr    = rd_addr_q;
  assign rd_data    = rd_data_q;
  assign rd_we      = rd_we_q;
  assign load_fault = fault_q;
  assign busy_mask  = busy_q;

endmodule

// File: tb/tb_rv32i_writeback.sv
// Scoreboard bench for rv32i_writeback: expected writes/faults are queued
// with their cycle; a negedge monitor pops and compares each DUT event.
module tb_rv32i_writeback;

  logic        clk;
  logic        rst_n;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_we;
  logic [31:0] busy_mask;
  logic        load_fault;

  rv32i_writeback_if exif ();

  rv32i_writeback #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex           (exif.slave),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_we        (rd_we),
    .busy_mask    (busy_mask),
    .load_fault   (load_fault)
  );

  typedef struct {
    bit          fault;
    logic [4:0]  a;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rd_we || load_fault) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: we=%b fault=%b addr=%0d data=%h",
                 rd_we, load_fault, rd_addr, rd_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("ev_fault", {31'd0, load_fault}, {31'd0, e.fault});
        chk("ev_we", {31'd0, rd_we}, {31'd0, !e.fault});
        chk("ev_cycle", cyc, e.cyc);
        if (!e.fault) begin
          chk("ev_addr", {27'd0, rd_addr}, {27'd0, e.a});
          chk("ev_data", rd_data, e.d);
        end
      end
    end
  end

  task automatic push_w(input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    e.fault = 1'b0; e.a = a; e.d = d; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic push_f();
    exp_t e;
    e.fault = 1'b1; e.a = '0; e.d = '0; e.cyc = cyc;
    q.push_back(e);
  endtask

  // Present an instruction and return #1 after the accepting edge.
  task automatic send(input logic [4:0] rd, input logic [31:0] res,
                      input logic ld, input logic [2:0] f3,
                      input logic [1:0] lo);
    bit ok;
    exif.ex_valid   = 1'b1;
    exif.ex_rd      = rd;
    exif.ex_result  = res;
    exif.ex_is_load = ld;
    exif.ex_funct3  = f3;
    exif.ex_addr_lo = lo;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = exif.ex_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: ex_ready stayed 0 expected 1");
    end
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] res);
    send(rd, res, 1'b0, 3'b000, 2'b00);
    if (rd != 5'd0) push_w(rd, res);
  endtask

  // Load: `dly` response-less WAIT_MEM cycles, then a response if `rsp`.
  task automatic load(input logic [4:0] rd, input logic [2:0] f3,
                      input logic [1:0] lo, input logic [31:0] data,
                      input int dly, input bit rsp,
                      input logic [31:0] expv);
    send(rd, 32'hBAD0BAD0, 1'b1, f3, lo);
    exif.ex_valid = 1'b0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("wait_ready", {31'd0, exif.ex_ready}, 32'd0);
      chk("wait_busy", busy_mask, 32'd1 << rd);
      @(posedge clk);
      #1;
    end
    if (rsp) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = data;
      @(negedge clk);
      chk("rsp_ready", {31'd0, exif.ex_ready}, 32'd0);
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      push_w(rd, expv);
      @(negedge clk);
      chk("wb_busy", busy_mask, 32'd1 << rd);
      @(posedge clk);
      #1;
    end else begin
      push_f();
    end
    @(negedge clk);
    chk("load_busy_clear", busy_mask, 32'd0);
    chk("load_ready", {31'd0, exif.ex_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    exif.ex_valid = 1'b0;
    exif.ex_rd = '0;
    exif.ex_result = '0;
    exif.ex_is_load = 1'b0;
    exif.ex_funct3 = '0;
    exif.ex_addr_lo = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, exif.ex_ready}, 32'd1);
    chk("rst_addr", {27'd0, rd_addr}, 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    alu(5'd5, 32'hDEADBEEF);
    exif.ex_valid = 1'b0;
    @(negedge clk);
    chk("alu_busy_n1", busy_mask, 32'h20);
    @(negedge clk);
    chk("alu_busy_n2", busy_mask, 32'h0);
    chk("alu_we_n2", {31'd0, rd_we}, 32'd0);
    @(posedge clk);
    #1;

    alu(5'd0, 32'h1234);
    exif.ex_valid = 1'b0;
    @(negedge clk);
    chk("x0_busy", busy_mask, 32'h0);
    @(posedge clk);
    #1;

    alu(5'd1, 32'd1);
    alu(5'd2, 32'd2);
    exif.ex_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy_x2", busy_mask, 32'h4);
    @(posedge clk);
    #1;

    load(5'd10, 3'b000, 2'd3, 32'h80FF7F01, 0, 1'b1, 32'hFFFFFF80);
    load(5'd11, 3'b100, 2'd1, 32'h80FF7F01, 0, 1'b1, 32'h0000007F);
    load(5'd12, 3'b001, 2'd2, 32'h80FF7F01, 0, 1'b1, 32'hFFFF80FF);
    load(5'd13, 3'b101, 2'd3, 32'h80FF7F01, 0, 1'b1, 32'h000080FF);
    load(5'd14, 3'b010, 2'd3, 32'h80FF7F01, 0, 1'b1, 32'h80FF7F01);
    load(5'd15, 3'b111, 2'd1, 32'h80FF7F01, 0, 1'b1, 32'h80FF7F01);

    load(5'd7, 3'b010, 2'd0, 32'h0BADF00D, 2, 1'b1, 32'h0BADF00D);

    load(5'd9, 3'b010, 2'd0, 32'h0, 4, 1'b0, 32'h0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h55555555;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("late_rsp_busy", busy_mask, 32'h0);
    @(posedge clk);
    #1;

    load(5'd9, 3'b001, 2'd0, 32'h00008001, 3, 1'b1, 32'hFFFF8001);

    send(5'd3, 32'h0, 1'b1, 3'b010, 2'd0);
    exif.ex_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, exif.ex_ready}, 32'd1);
    chk("mid_rst_addr", {27'd0, rd_addr}, 32'd0);
    chk("mid_rst_data", rd_data, 32'd0);
    chk("mid_rst_busy", busy_mask, 32'd0);
    chk("mid_rst_fault", {31'd0, load_fault}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    mem_rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", busy_mask, 32'd0);
    chk("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
